video_render_sched: RTL and testbench

- Per-line render scheduler between the 640x480 VGA timing generator and the layer/sprite renderers.
- Consumes the timing strobes next_frame, next_line and vblank_pulse.
- Sequences up to three renderers (layer0, layer1, sprites) through a start/done handshake for each line.
- Controls the ping-pong line-buffer select, flags render overruns, and raises vsync and line-match interrupts.

---
 rtl/video_render_sched.sv | 157 +++++++++++++++
 tb/tb_video_render_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_render_sched.sv
// Per-line render scheduler: walks the enabled renderers through a start/done handshake
// on every active scan line, flips the ping-pong line buffers and raises vsync/line irqs.
module video_render_sched #(
  parameter int unsigned ACTIVE_LINES = 480,
  parameter int unsigned NUM_REQ      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               next_frame,
  input  logic               next_line,
  input  logic               vblank_pulse,
  input  logic [NUM_REQ-1:0] layer_en,
  input  logic [8:0]         irq_line_cfg,
  input  logic [1:0]         irq_ack,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] start,
  output logic               abort,
  output logic [8:0]         render_line,
  output logic               lb_wr_sel,
  output logic               lb_rd_sel,
  output logic               busy,
  output logic               overrun,
  output logic               irq_vsync,
  output logic               irq_line
);

  localparam int unsigned IdxW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [9:0]  LinesMax = 10'(ACTIVE_LINES);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e             state_q, state_d;
  logic [9:0]         line_q, line_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] start_q, start_d;
  logic [IdxW-1:0]    cur_q, cur_d;
  logic               lb_wr_sel_q, lb_wr_sel_d;
  logic               overrun_q, overrun_d;
  logic               abort_q, abort_d;
  logic               irq_vsync_q, irq_vsync_d;
  logic               irq_line_q, irq_line_d;

  logic               strobe;
  logic               line_valid;
  logic               is_busy;
  logic               found;
  logic [IdxW-1:0]    sel;

  // Line counter; sits at ACTIVE_LINES (invalid) through vblank until the next frame.
  always_comb begin
    line_d = line_q;
    if (next_frame) begin
      line_d = '0;
    end else if (next_line) begin
      line_d = (line_q >= LinesMax) ? LinesMax : line_q + 10'd1;
    end
  end

  assign strobe     = next_frame | next_line;
  assign line_valid = (line_d < LinesMax);
  assign is_busy    = (state_q != StIdle);

  // Lowest pending renderer wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        found = 1'b1;
        sel   = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    start_d = '0;
    if (strobe) begin
      // A new line always preempts whatever is left of the current sequence.
      if (line_valid) begin
        state_d = StLaunch;
        pend_d  = layer_en;
      end else begin
        state_d = StIdle;
        pend_d  = '0;
      end
    end else begin
      unique case (state_q)
        StLaunch: begin
          if (found) begin
            start_d[sel] = 1'b1;
            pend_d[sel]  = 1'b0;
            cur_d        = sel;
            state_d      = StWait;
          end else begin
            state_d = StIdle;
          end
        end
        StWait: begin
          if (done[cur_q]) begin
            state_d = StLaunch;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    overrun_d   = strobe & is_busy;
    abort_d     = strobe & is_busy;
    lb_wr_sel_d = lb_wr_sel_q ^ (strobe & line_valid);
    // Set has priority over acknowledge on both interrupts.
    irq_vsync_d = vblank_pulse | (irq_vsync_q & ~irq_ack[0]);
    irq_line_d  = (strobe & line_valid & (line_d[8:0] == irq_line_cfg)) |
                  (irq_line_q & ~irq_ack[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      line_q      <= LinesMax;
      pend_q      <= '0;
      start_q     <= '0;
      cur_q       <= '0;
      lb_wr_sel_q <= 1'b0;
      overrun_q   <= 1'b0;
      abort_q     <= 1'b0;
      irq_vsync_q <= 1'b0;
      irq_line_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      pend_q      <= pend_d;
      start_q     <= start_d;
      cur_q       <= cur_d;
      lb_wr_sel_q <= lb_wr_sel_d;
      overrun_q   <= overrun_d;
      abort_q     <= abort_d;
      irq_vsync_q <= irq_vsync_d;
      irq_line_q  <= irq_line_d;
    end
  end

  assign start       = start_q;
  assign abort       = abort_q;
  assign render_line = line_q[8:0];
  assign lb_wr_sel   = lb_wr_sel_q;
  assign lb_rd_sel   = ~lb_wr_sel_q;
  assign busy        = is_busy;
  assign overrun     = overrun_q;
  assign irq_vsync   = irq_vsync_q;
  assign irq_line    = irq_line_q;

endmodule

// File: tb/tb_video_render_sched.sv
// Scoreboard bench for video_render_sched: expected start/overrun events are queued by the
// stimulus and consumed by a monitor whenever the scheduler emits them.
module tb_video_render_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       next_frame, next_line, vblank_pulse;
  logic [2:0] layer_en;
  logic [8:0] irq_line_cfg;
  logic [1:0] irq_ack;
  logic [2:0] done;
  logic [2:0] start;
  logic       abort, lb_wr_sel, lb_rd_sel, busy, overrun, irq_vsync, irq_line;
  logic [8:0] render_line;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_start[$];  // {start, render_line}
  logic [10:0] exp_ovr[$];    // {overrun, abort, render_line}
  logic [2:0]  withhold = 3'b000;
  int          dcnt[3] = '{0, 0, 0};

  video_render_sched dut (
    .clk          (clk),
    .rst          (rst),
    .next_frame   (next_frame),
    .next_line    (next_line),
    .vblank_pulse (vblank_pulse),
    .layer_en     (layer_en),
    .irq_line_cfg (irq_line_cfg),
    .irq_ack      (irq_ack),
    .done         (done),
    .start        (start),
    .abort        (abort),
    .render_line  (render_line),
    .lb_wr_sel    (lb_wr_sel),
    .lb_rd_sel    (lb_rd_sel),
    .busy         (busy),
    .overrun      (overrun),
    .irq_vsync    (irq_vsync),
    .irq_line     (irq_line)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Renderer model: done comes back 5 cycles after start unless withheld; abort kills work.
  initial begin
    done = 3'b000;
    forever begin
      @(negedge clk);
      done = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (rst || abort) begin
          dcnt[i] = 0;
        end else if (dcnt[i] > 0) begin
          dcnt[i]--;
          if (dcnt[i] == 0 && !withhold[i]) done[i] = 1'b1;
        end
        if (start[i] && !rst) dcnt[i] = 4;
      end
    end
  end

  // Monitor: every emitted start / overrun must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (start != 3'b000) begin
        if (exp_start.size() == 0) check("start_unexpected", {start, render_line}, 0);
        else check("start_seq", {start, render_line}, exp_start.pop_front());
      end
      if (overrun || abort) begin
        if (exp_ovr.size() == 0) check("overrun_unexpected", {overrun, abort, render_line}, 0);
        else check("overrun_abort", {overrun, abort, render_line}, exp_ovr.pop_front());
      end
    end
  end

  task automatic pulse_line(input logic frame);
    @(negedge clk);
    next_line  = 1'b1;
    next_frame = frame;
    @(negedge clk);
    next_line  = 1'b0;
    next_frame = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < maxc);
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    next_frame = 1'b0; next_line = 1'b0; vblank_pulse = 1'b0;
    layer_en = 3'b111; irq_line_cfg = 9'd100; irq_ack = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_start", start, 0);
    check("rst_abort", abort, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_irqs", {irq_vsync, irq_line}, 0);
    check("rst_lb", {lb_wr_sel, lb_rd_sel}, 2'b01);
    check("rst_line", render_line, 9'd480);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame start, all three renderers.
    exp_start.push_back({3'b001, 9'd0});
    exp_start.push_back({3'b010, 9'd0});
    exp_start.push_back({3'b100, 9'd0});
    pulse_line(1'b1);
    check("f0_line", render_line, 9'd0);
    check("f0_lb", {lb_wr_sel, lb_rd_sel}, 2'b10);
    repeat (18) @(negedge clk);
    check("f0_busy_last", busy, 1);
    @(negedge clk);
    check("f0_busy_drop", busy, 0);

    // Renderer 1 disabled.
    layer_en = 3'b101;
    exp_start.push_back({3'b001, 9'd1});
    exp_start.push_back({3'b100, 9'd1});
    pulse_line(1'b0);
    wait_idle(40);
    check("l1_line", render_line, 9'd1);
    check("l1_lb", lb_wr_sel, 0);

    // Nothing enabled: one LAUNCH cycle only.
    layer_en = 3'b000;
    pulse_line(1'b0);
    check("l2_busy_launch", busy, 1);
    @(negedge clk);
    check("l2_busy_idle", busy, 0);
    check("l2_lb", lb_wr_sel, 1);
    check("l2_line", render_line, 9'd2);

    // Overrun: done[2] withheld, next line arrives during WAIT(2).
    layer_en = 3'b111;
    withhold = 3'b100;
    exp_start.push_back({3'b001, 9'd3});
    exp_start.push_back({3'b010, 9'd3});
    exp_start.push_back({3'b100, 9'd3});
    pulse_line(1'b0);
    repeat (14) @(negedge clk);
    check("l3_waiting", busy, 1);
    exp_ovr.push_back({1'b1, 1'b1, 9'd4});
    exp_start.push_back({3'b001, 9'd4});
    exp_start.push_back({3'b010, 9'd4});
    exp_start.push_back({3'b100, 9'd4});
    pulse_line(1'b0);
    withhold = 3'b000;
    check("l4_line", render_line, 9'd4);
    wait_idle(40);
    check("l4_lb", lb_wr_sel, 1);

    // Run out the frame with nothing enabled; line irq at 100.
    layer_en = 3'b000;
    for (int ln = 5; ln < 480; ln++) begin
      pulse_line(1'b0);
      if (ln == 99) check("irq_line_before", irq_line, 0);
      if (ln == 100) check("irq_line_at", irq_line, 1);
    end
    check("l479_line", render_line, 9'd479);
    check("l479_lb", lb_wr_sel, 0);
    layer_en = 3'b111;
    pulse_line(1'b0);
    check("l480_line", render_line, 9'd480);
    check("l480_lb", lb_wr_sel, 0);
    check("l480_busy", busy, 0);
    pulse_line(1'b0);
    check("l480_sat", render_line, 9'd480);
    @(negedge clk);
    irq_ack = 2'b10;
    @(negedge clk);
    irq_ack = 2'b00;
    check("irq_line_ack", irq_line, 0);

    // New frame reloads line 0.
    layer_en = 3'b001;
    exp_start.push_back({3'b001, 9'd0});
    pulse_line(1'b1);
    check("f1_line", render_line, 9'd0);
    check("f1_lb", lb_wr_sel, 1);
    wait_idle(20);

    // vsync irq: set beats ack, then ack alone clears.
    @(negedge clk);
    vblank_pulse = 1'b1; irq_ack = 2'b01;
    @(negedge clk);
    vblank_pulse = 1'b0; irq_ack = 2'b00;
    check("irq_vsync_set_wins", irq_vsync, 1);
    irq_ack = 2'b01;
    @(negedge clk);
    irq_ack = 2'b00;
    check("irq_vsync_ack", irq_vsync, 0);

    // Async reset in the middle of a sequence.
    layer_en = 3'b111;
    exp_start.push_back({3'b001, 9'd1});
    pulse_line(1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_line", render_line, 9'd480);
    check("arst_lb", {lb_wr_sel, lb_rd_sel}, 2'b01);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_idle", busy, 0);

    check("start_queue_drained", exp_start.size(), 0);
    check("overrun_queue_drained", exp_ovr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
